// File: rtl/soe_hrx2_to_si_10_nil_pkg.sv
`default_nettype none
// ============================================================================
// Module : soe_hrx2_to_si_10_nil_pkg
// Brief  : Shared constants and state encoding for the half-rate-x2 path.
// Rev    : 1.0
// ============================================================================
package soe_hrx2_to_si_10_nil_pkg;

    localparam int HRX2_IN_WIDTH = 10;
    localparam int HRX2_HALF_LEN = 5;
    localparam int HRX2_VEC_LEN  = 10;

    localparam logic SER_LO = 1'b0;
    localparam logic SER_HI = 1'b1;

    typedef enum logic [0:0] {
        EXP_LO = 1'b0,
        EXP_HI = 1'b1
    } hrx2_state_t;

endpackage : soe_hrx2_to_si_10_nil_pkg
`default_nettype wire

// File: rtl/soe_hrx2_to_si_10_nil_if.sv
`default_nettype none
// ============================================================================
// Module : soe_hrx2_to_si_10_nil_if
// Brief  : Half-beat input and reassembled-vector output bundle.
// Rev    : 1.0
// ============================================================================
interface soe_hrx2_to_si_10_nil_if
    import soe_hrx2_to_si_10_nil_pkg::*;
#(
    parameter int IN_WIDTH = HRX2_IN_WIDTH
);
    logic                       enable;
    logic                       inReady;
    logic                       inSeries;
    logic signed [IN_WIDTH-1:0] I0, I1, I2, I3, I4;
    logic signed [IN_WIDTH-1:0] O0, O1, O2, O3, O4, O5, O6, O7, O8, O9;
    logic                       outReady;
    logic                       expectHigh;
    logic                       seqError;

    modport master (
        output enable, inReady, inSeries, I0, I1, I2, I3, I4,
        input  O0, O1, O2, O3, O4, O5, O6, O7, O8, O9,
        input  outReady, expectHigh, seqError
    );

    modport slave (
        input  enable, inReady, inSeries, I0, I1, I2, I3, I4,
        output O0, O1, O2, O3, O4, O5, O6, O7, O8, O9,
        output outReady, expectHigh, seqError
    );
endinterface : soe_hrx2_to_si_10_nil_if
`default_nettype wire

// File: rtl/soe_hrx2_to_si_10_nil_half_reg.sv
`default_nettype none
// ============================================================================
// Module : hrx2_half_reg
// Brief  : Five-lane register bank with load enable and async reset.
// Rev    : 1.0
// ============================================================================
module hrx2_half_reg
    import soe_hrx2_to_si_10_nil_pkg::*;
#(
    parameter int IN_WIDTH = HRX2_IN_WIDTH
) (
    input  wire logic                                     clk,
    input  wire logic                                     rst,
    input  wire logic                                     i_load,
    input  wire logic [HRX2_HALF_LEN-1:0][IN_WIDTH-1:0]   i_d,
    output logic      [HRX2_HALF_LEN-1:0][IN_WIDTH-1:0]   o_q
);

    logic [HRX2_HALF_LEN-1:0][IN_WIDTH-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : hrx2_half_reg
`default_nettype wire

// File: rtl/soe_hrx2_to_si_10_nil.sv
`default_nettype none
// ============================================================================
// Module : soe_hrx2_to_si_10_nil
// Brief  : Reassembles low/high 5-lane half beats into one registered 10-lane vector.
// Rev    : 1.0
// ============================================================================
module soe_hrx2_to_si_10_nil
    import soe_hrx2_to_si_10_nil_pkg::*;
#(
    parameter int IN_WIDTH = HRX2_IN_WIDTH
) (
    input  wire logic               clk,
    input  wire logic               reset,
    soe_hrx2_to_si_10_nil_if.slave  bus
);

    hrx2_state_t r_state;
    hrx2_state_t w_state_nxt;
    logic        r_out_ready;
    logic        r_seq_err;
    logic        w_out_ready_nxt;
    logic        w_seq_err_nxt;
    logic        w_load_l;
    logic        w_load_o;
    logic        w_acc;

    logic [HRX2_HALF_LEN-1:0][IN_WIDTH-1:0] w_in;
    logic [HRX2_HALF_LEN-1:0][IN_WIDTH-1:0] w_lo_hold;
    logic [HRX2_HALF_LEN-1:0][IN_WIDTH-1:0] w_o_lo;
    logic [HRX2_HALF_LEN-1:0][IN_WIDTH-1:0] w_o_hi;

    assign w_acc = bus.enable & bus.inReady;
    assign w_in  = {bus.I4, bus.I3, bus.I2, bus.I1, bus.I0};

    always_comb begin
        w_state_nxt     = r_state;
        w_load_l        = 1'b0;
        w_load_o        = 1'b0;
        w_out_ready_nxt = 1'b0;
        w_seq_err_nxt   = 1'b0;
        if (w_acc) begin
            case (r_state)
                EXP_LO: begin
                    if (bus.inSeries == SER_LO) begin
                        w_load_l    = 1'b1;
                        w_state_nxt = EXP_HI;
                    end else begin
                        w_seq_err_nxt = 1'b1;
                    end
                end
                EXP_HI: begin
                    if (bus.inSeries == SER_HI) begin
                        w_load_o        = 1'b1;
                        w_out_ready_nxt = 1'b1;
                        w_state_nxt     = EXP_LO;
                    end else begin
                        // A second low half replaces the stale one; the pair restarts.
                        w_load_l      = 1'b1;
                        w_seq_err_nxt = 1'b1;
                    end
                end
                default: w_state_nxt = EXP_LO;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= EXP_LO;
            r_out_ready <= 1'b0;
            r_seq_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_ready <= w_out_ready_nxt;
            r_seq_err   <= w_seq_err_nxt;
        end
    end

    hrx2_half_reg #(.IN_WIDTH(IN_WIDTH)) u_hold_lo (
        .clk    (clk),
        .rst    (reset),
        .i_load (w_load_l),
        .i_d    (w_in),
        .o_q    (w_lo_hold)
    );

    hrx2_half_reg #(.IN_WIDTH(IN_WIDTH)) u_out_lo (
        .clk    (clk),
        .rst    (reset),
        .i_load (w_load_o),
        .i_d    (w_lo_hold),
        .o_q    (w_o_lo)
    );

    hrx2_half_reg #(.IN_WIDTH(IN_WIDTH)) u_out_hi (
        .clk    (clk),
        .rst    (reset),
        .i_load (w_load_o),
        .i_d    (w_in),
        .o_q    (w_o_hi)
    );

    assign bus.O0 = w_o_lo[0];
    assign bus.O1 = w_o_lo[1];
    assign bus.O2 = w_o_lo[2];
    assign bus.O3 = w_o_lo[3];
    assign bus.O4 = w_o_lo[4];
    assign bus.O5 = w_o_hi[0];
    assign bus.O6 = w_o_hi[1];
    assign bus.O7 = w_o_hi[2];
    assign bus.O8 = w_o_hi[3];
    assign bus.O9 = w_o_hi[4];

    assign bus.outReady   = r_out_ready;
    assign bus.seqError   = r_seq_err;
    assign bus.expectHigh = (r_state == EXP_HI);

endmodule : soe_hrx2_to_si_10_nil
`default_nettype wire

// File: tb/tb_soe_hrx2_to_si_10_nil.sv
`default_nettype none
// ============================================================================
// Module : tb_soe_hrx2_to_si_10_nil
// Brief  : Directed vector table, hand sequences and randomized model check.
// Rev    : 1.0
// ============================================================================
module tb_soe_hrx2_to_si_10_nil;
    import soe_hrx2_to_si_10_nil_pkg::*;

    typedef logic [4:0][9:0] half_t;
    typedef logic [9:0][9:0] vec_t;

    typedef struct packed {
        logic  en;
        logic  rdy;
        logic  ser;
        half_t d;
        logic  e_or;
        logic  e_se;
        logic  e_eh;
        logic  chk_o;
        vec_t  e_o;
    } row_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    soe_hrx2_to_si_10_nil_if #(.IN_WIDTH(10)) bus ();

    soe_hrx2_to_si_10_nil #(.IN_WIDTH(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic half_t h5(input int a, input int b, input int c, input int d, input int e);
        half_t r;
        r[0] = 10'(a); r[1] = 10'(b); r[2] = 10'(c); r[3] = 10'(d); r[4] = 10'(e);
        return r;
    endfunction

    function automatic vec_t get_o();
        return {bus.O9, bus.O8, bus.O7, bus.O6, bus.O5, bus.O4, bus.O3, bus.O2, bus.O1, bus.O0};
    endfunction

    function automatic row_t mk(input logic en, input logic rdy, input logic ser, input half_t d,
                                input logic eor, input logic ese, input logic eeh,
                                input logic chk, input vec_t eo);
        row_t r;
        r.en = en; r.rdy = rdy; r.ser = ser; r.d = d;
        r.e_or = eor; r.e_se = ese; r.e_eh = eeh; r.chk_o = chk; r.e_o = eo;
        return r;
    endfunction

    task automatic chk(input string name, input logic [99:0] act, input logic [99:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic rdy, input logic ser, input half_t d);
        bus.enable   = en;
        bus.inReady  = rdy;
        bus.inSeries = ser;
        bus.I0 = d[0]; bus.I1 = d[1]; bus.I2 = d[2]; bus.I3 = d[3]; bus.I4 = d[4];
    endtask

    task automatic step_chk(input string tag, input logic en, input logic rdy, input logic ser,
                            input half_t d, input logic eor, input logic ese, input logic eeh,
                            input logic do_o, input vec_t eo);
        drive(en, rdy, ser, d);
        @(posedge clk);
        #1;
        chk({tag, ".outReady"},   100'(bus.outReady),   100'(eor));
        chk({tag, ".seqError"},   100'(bus.seqError),   100'(ese));
        chk({tag, ".expectHigh"}, 100'(bus.expectHigh), 100'(eeh));
        if (do_o) chk({tag, ".O"}, get_o(), eo);
    endtask

    row_t  tbl[$];
    half_t pend[$];
    vec_t  m_o;
    vec_t  v_prev;
    half_t z5;

    initial begin
        n_cmp = 0;
        n_err = 0;
        z5    = h5(0, 0, 0, 0, 0);
        drive(1'b0, 1'b0, 1'b0, z5);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.outReady",   100'(bus.outReady),   100'(0));
        chk("reset.seqError",   100'(bus.seqError),   100'(0));
        chk("reset.expectHigh", 100'(bus.expectHigh), 100'(0));
        chk("reset.O",          get_o(),              100'(0));
        reset = 1'b0;

        // Orphan high half first, then a clean pair.
        tbl.push_back(mk(1, 1, 1, h5(7, 7, 7, 7, 7), 0, 1, 0, 1, '0));
        tbl.push_back(mk(1, 1, 0, h5(40, 41, 42, 43, 44), 0, 0, 1, 1, '0));
        tbl.push_back(mk(1, 1, 1, h5(45, 46, 47, 48, 49), 1, 0, 0, 1,
                         {h5(45, 46, 47, 48, 49), h5(40, 41, 42, 43, 44)}));
        // Basic pair with signed data, then an idle cycle.
        tbl.push_back(mk(1, 1, 0, h5(1, 2, 3, 4, 5), 0, 0, 1, 0, '0));
        tbl.push_back(mk(1, 1, 1, h5(-1, -2, -3, -4, -5), 1, 0, 0, 1,
                         {h5(-1, -2, -3, -4, -5), h5(1, 2, 3, 4, 5)}));
        tbl.push_back(mk(1, 0, 0, z5, 0, 0, 0, 1,
                         {h5(-1, -2, -3, -4, -5), h5(1, 2, 3, 4, 5)}));
        // Back-to-back pairs.
        tbl.push_back(mk(1, 1, 0, h5(100, 101, 102, 103, 104), 0, 0, 1, 0, '0));
        tbl.push_back(mk(1, 1, 1, h5(110, 111, 112, 113, 114), 1, 0, 0, 1,
                         {h5(110, 111, 112, 113, 114), h5(100, 101, 102, 103, 104)}));
        tbl.push_back(mk(1, 1, 0, h5(120, 121, 122, 123, 124), 0, 0, 1, 1,
                         {h5(110, 111, 112, 113, 114), h5(100, 101, 102, 103, 104)}));
        tbl.push_back(mk(1, 1, 1, h5(130, 131, 132, 133, 134), 1, 0, 0, 1,
                         {h5(130, 131, 132, 133, 134), h5(120, 121, 122, 123, 124)}));
        // Double low half: the second replaces the first.
        tbl.push_back(mk(1, 1, 0, h5(10, 11, 12, 13, 14), 0, 0, 1, 0, '0));
        tbl.push_back(mk(1, 1, 0, h5(20, 21, 22, 23, 24), 0, 1, 1, 0, '0));
        tbl.push_back(mk(1, 1, 1, h5(30, 31, 32, 33, 34), 1, 0, 0, 1,
                         {h5(30, 31, 32, 33, 34), h5(20, 21, 22, 23, 24)}));

        foreach (tbl[i]) begin
            step_chk($sformatf("tbl%0d", i), tbl[i].en, tbl[i].rdy, tbl[i].ser, tbl[i].d,
                     tbl[i].e_or, tbl[i].e_se, tbl[i].e_eh, tbl[i].chk_o, tbl[i].e_o);
        end

        // Freeze with enable low while a low half is held.
        v_prev = {h5(30, 31, 32, 33, 34), h5(20, 21, 22, 23, 24)};
        step_chk("frz.lo", 1, 1, 0, h5(50, 51, 52, 53, 54), 0, 0, 1, 1, v_prev);
        for (int k = 0; k < 3; k++) begin
            step_chk($sformatf("frz%0d", k), 0, 1, 1, h5(60, 61, 62, 63, 64), 0, 0, 1, 1, v_prev);
        end
        step_chk("frz.hi", 1, 1, 1, h5(60, 61, 62, 63, 64), 1, 0, 0, 1,
                 {h5(60, 61, 62, 63, 64), h5(50, 51, 52, 53, 54)});

        // Asynchronous reset mid-pair, then extremes.
        step_chk("rst.lo", 1, 1, 0, h5(9, 9, 9, 9, 9), 0, 0, 1, 0, '0);
        drive(1'b0, 1'b0, 1'b0, z5);
        #2 reset = 1'b1;
        #1;
        chk("arst.O",          get_o(),              100'(0));
        chk("arst.expectHigh", 100'(bus.expectHigh), 100'(0));
        chk("arst.outReady",   100'(bus.outReady),   100'(0));
        #1 reset = 1'b0;
        step_chk("rst.hi", 1, 1, 1, h5(3, 3, 3, 3, 3), 0, 1, 0, 1, '0);
        step_chk("ext.lo", 1, 1, 0, h5(-512, 511, -512, 511, -1), 0, 0, 1, 1, '0);
        step_chk("ext.hi", 1, 1, 1, h5(511, -512, 0, 1, -1), 1, 0, 0, 1,
                 {h5(511, -512, 0, 1, -1), h5(-512, 511, -512, 511, -1)});

        // Randomized run against a queue-based pairing model.
        drive(1'b0, 1'b0, 1'b0, z5);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        pend.delete();
        m_o = '0;
        for (int c = 0; c < 400; c++) begin
            logic  en, rdy, ser, eor, ese;
            half_t d;
            en  = ($urandom_range(0, 7) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            ser = 1'($urandom);
            for (int j = 0; j < 5; j++) d[j] = 10'($urandom);
            eor = 1'b0;
            ese = 1'b0;
            if (en && rdy) begin
                if (ser == SER_LO) begin
                    if (pend.size() != 0) begin
                        ese = 1'b1;
                        pend.delete();
                    end
                    pend.push_back(d);
                end else if (pend.size() == 0) begin
                    ese = 1'b1;
                end else begin
                    m_o = {d, pend.pop_front()};
                    eor = 1'b1;
                end
            end
            step_chk($sformatf("rnd%0d", c), en, rdy, ser, d, eor, ese,
                     (pend.size() != 0), 1'b1, m_o);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_soe_hrx2_to_si_10_nil
`default_nettype wire
